// File: rtl/rice_feeder.sv
// rice_feeder: serial Rice decoder producing zigzag-unfolded signed residuals, one bit per enabled cycle.
module rice_feeder (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iData,
    input  logic [3:0]  iRiceParam,
    output logic [15:0] oData,
    output logic        oDone
);
    typedef enum logic {UNARY, BINARY} state_t;
    state_t      state_q, state_d;
    logic [15:0] q_q, q_d, r_q, r_d, data_q, data_d;
    logic [3:0]  cnt_q, cnt_d, k_q, k_d, k_eff;
    logic        done_q, done_d;
    logic [31:0] u;
    // q only leaves zero via a zero bit, so UNARY with q==0 marks a codeword's first bit
    assign k_eff = (state_q == UNARY && q_q == 16'd0) ? iRiceParam : k_q;
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        done_d  = 1'b0;
        u       = 32'd0;
        if (iEnable) begin
            if (state_q == UNARY) begin
                k_d = k_eff;
                if (!iData) begin
                    q_d = (q_q == 16'hFFFF) ? q_q : q_q + 16'd1;
                end else if (k_eff == 4'd0) begin
                    u      = {16'd0, q_q};
                    done_d = 1'b1;
                    q_d    = 16'd0;
                end else begin
                    state_d = BINARY;
                    cnt_d   = k_eff;
                end
            end else begin
                r_d   = {r_q[14:0], iData};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    u       = ({16'd0, q_q} << k_q) | {16'd0, r_d};
                    done_d  = 1'b1;
                    state_d = UNARY;
                    q_d     = 16'd0;
                    r_d     = 16'd0;
                end
            end
        end
        data_d = done_d ? (u[0] ? ~u[16:1] : u[16:1]) : data_q;
    end
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q <= UNARY;
            q_q     <= 16'd0;
            r_q     <= 16'd0;
            cnt_q   <= 4'd0;
            k_q     <= 4'd0;
            data_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end
    assign oData = data_q;
    assign oDone = done_q;
endmodule

// File: tb/tb_rice_feeder.sv
// tb_rice_feeder: randomized and directed checks of rice_feeder against an arithmetic Rice/zigzag model.
module tb_rice_feeder;
    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iEnable = 1'b0;
    logic        iData = 1'b0;
    logic [3:0]  iRiceParam = 4'd0;
    logic [15:0] oData;
    logic        oDone;
    logic [15:0] exp_data = 16'd0;
    int          checks = 0;
    int          failures = 0;

    rice_feeder dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iData(iData),
        .iRiceParam(iRiceParam), .oData(oData), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    function automatic logic [15:0] zz(input longint q, input longint k, input longint r);
        longint u, v;
        u = q * (longint'(1) << k) + r;
        v = (u % 2 == 1) ? -(u / 2) - 1 : u / 2;
        return v[15:0];
    endfunction

    task automatic send_bit(input logic d, input logic [3:0] kp, input logic last, input logic en, input string tag);
        iEnable = en;
        iData = d;
        iRiceParam = kp;
        @(posedge iClock);
        #1;
        checks++;
        if (oDone !== (last && en)) begin
            failures++;
            $display("FAIL %s done: got %b expected %b", tag, oDone, last && en);
        end
        checks++;
        if (oData !== exp_data) begin
            failures++;
            $display("FAIL %s data: got %0d expected %0d", tag, $signed(oData), $signed(exp_data));
        end
    endtask

    task automatic send_codeword(input int q, input int k, input int r, input int gap_at, input int gap_len, input string tag);
        logic bits[$];
        for (int i = 0; i < q; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        for (int j = k - 1; j >= 0; j--) bits.push_back(r[j]);
        for (int i = 0; i < bits.size(); i++) begin
            if (i == gap_at)
                repeat (gap_len) send_bit(1'($urandom), 4'($urandom), 1'b0, 1'b0, tag);
            if (i == bits.size() - 1) exp_data = zz(q, k, r);
            send_bit(bits[i], (i == 0) ? 4'(k) : 4'($urandom), i == bits.size() - 1, 1'b1, tag);
        end
    endtask

    task automatic test_reset();
        iReset = 1'b0;
        repeat (2) send_bit(1'($urandom), 4'($urandom), 1'b0, 1'b1, "reset");
        iReset = 1'b1;
    endtask

    task automatic test_vectors();
        send_codeword(5, 3, 5, -1, 0, "vec_m23");
        send_codeword(2, 3, 6, -1, 0, "vec_11");
        send_codeword(0, 3, 2, -1, 0, "vec_1");
        send_codeword(10, 3, 7, -1, 0, "vec_m44");
    endtask

    task automatic test_k0();
        send_codeword(0, 0, 0, -1, 0, "k0_0");
        send_codeword(1, 0, 0, -1, 0, "k0_m1");
        send_codeword(2, 0, 0, -1, 0, "k0_1");
    endtask

    task automatic test_enable_gap();
        send_codeword(5, 3, 5, 7, 3, "gap");
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0, 4'd3, 1'b0, 1'b1, "rst_mid_part");
        send_bit(1'b1, 4'd3, 1'b0, 1'b1, "rst_mid_part");
        send_bit(1'b1, 4'd3, 1'b0, 1'b1, "rst_mid_part");
        iReset = 1'b0;
        exp_data = 16'd0;
        send_bit(1'b1, 4'd3, 1'b0, 1'b1, "rst_mid_clear");
        iReset = 1'b1;
        send_codeword(5, 3, 5, -1, 0, "rst_mid_after");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 15);
            send_codeword($urandom_range(0, 20), k, int'($urandom) & ((1 << k) - 1),
                          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1, $urandom_range(1, 4), "random");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_k0();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
